fifo_burst_sum: RTL and testbench
=================================

// Module: fifo_burst_sum
// PURPOSE
//  - Consumer stage directly downstream of the one-element FIFO's dequeue side (first/deq method pair).
//  - Pulls BURST_LEN consecutive words, sums them, and offers one result word to the next FIFO's enqueue method.
//  - Uses the codebase's ENA/RDY method handshake on both sides; a method fires in a cycle where ENA && RDY.
// PARAMETERS
//  - DATA_W     32  width of input words and of the result word
//  - BURST_LEN  4   words per burst; legal range 2..256
// PORTS
//  - CLK            in   1       clock, all state updates on posedge
//  - nRST           in   1       reset, synchronous, active-low
//  - in_first       in   DATA_W  head word of upstream FIFO
//  - in_first__RDY  in   1       in_first is valid
//  - in_deq__RDY    in   1       upstream deq may fire
//  - in_deq__ENA    out  1       dequeue the head word this cycle
//  - out_enq_v      out  DATA_W  burst sum offered downstream
//  - out_enq__ENA   out  1       enqueue out_enq_v this cycle
//  - out_enq__RDY   in   1       downstream FIFO can accept
//  - bursts_done    out  16      count of emitted bursts, wraps at 2^16
//  - busy           out  1       high when state != COLLECT or cnt != 0
//  - sum_ovf        out  1       sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - States: COLLECT (accumulating), EMIT (result held, waiting for downstream).
//  - Reset (nRST low at posedge): state=COLLECT, acc=0, cnt=0, bursts_done=0, sum_ovf=0.
//    All outputs read 0 while held in reset. Reset mid-burst discards the partial sum.
//  - take = in_first__RDY && in_deq__RDY && (state==COLLECT || emit_fire).
//  - in_deq__ENA = take. ENA is never asserted while RDY is low.
//  - COLLECT on take:
//    - cnt==0: acc <= in_first.
//    - otherwise: acc <= acc + in_first.
//    - cnt increments by 1.
//    - When cnt==BURST_LEN-1: go to EMIT and clear cnt.
//  - EMIT:
//    - out_enq__ENA = 1 and out_enq_v = acc, held stable until the enqueue fires.
//    - emit_fire = out_enq__ENA && out_enq__RDY.
//    - On emit_fire: bursts_done += 1. Go to COLLECT unless the same-cycle take below applies.
//  - Simultaneous emit_fire and take (back-to-back bursts):
//    - acc <= in_first and cnt <= 1, with no bubble.
//    - If BURST_LEN==1 were legal this would need EMIT->EMIT; it is excluded by the parameter range.
//  - Latency and throughput:
//    - Result is presented the cycle after the last word is dequeued.
//    - Sustained throughput is 1 word/cycle when downstream is always ready.
//  - Upstream empty (in_first__RDY=0): no deq, state and acc hold.
//    Downstream full: EMIT holds indefinitely and upstream stalls.
//  - Arithmetic: default sum is modulo 2^DATA_W (carry dropped). cnt is CNT_W=$clog2(BURST_LEN) bits.
// CONFIGURATION
//  - Macro FIFO_BURST_SUM_SAT_EN.
//  - Defined:
//    - The adder computes in DATA_W+1 bits.
//    - On carry out, acc saturates at {DATA_W{1'b1}} and stays saturated for the rest of the burst.
//    - sum_ovf is set and remains set until reset.
//  - Undefined: wrap-around sum; sum_ovf is tied to 0.
// STRUCTURE
//  - Package fifo_burst_sum_pkg holds:
//    - typedef enum {COLLECT, EMIT} state_t
//    - localparam BURSTS_W=16
//    - function clog2 for CNT_W
//  - Sub-module fifo_burst_sum_acc: combinational adder plus optional saturation.
//    Inputs: acc, word, first. Outputs: next_acc, ovf.
//  - The macro is consumed only inside fifo_burst_sum_acc.
// TESTING
//  - Reset, then words 1,2,3,4 with downstream ready ->
//    out_enq__ENA for one cycle with v=10, then bursts_done=1 and busy=0.
//  - Hold out_enq__RDY=0 for 5 cycles after a burst ->
//    out_enq_v stable, in_deq__ENA=0 throughout, exactly one enqueue on release.
//  - Continuous stream of 8 words with both sides always ready ->
//    sums 10 and 26 emitted, no idle cycle between bursts, bursts_done=2.
//  - Upstream gaps (in_first__RDY toggling every cycle) ->
//    same sums as the gapless run, with no deq while RDY=0.
//  - Words 0xFFFFFFFF,2,0,0:
//    - SAT_EN off: v=0x00000001, sum_ovf=0.
//    - SAT_EN on: v=0xFFFFFFFF, sum_ovf=1.
//  - nRST low after 2 words of a burst, then 4 words 5,5,5,5 -> v=20 and bursts_done=1.

Source files
------------

// File: rtl/fifo_burst_sum_pkg.sv
// Shared types and constants for the burst-sum consumer stage.
package fifo_burst_sum_pkg;

  typedef enum logic [0:0] {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  localparam int BURSTS_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_burst_sum_if.sv
// ENA/RDY method bundle: upstream first/deq pair and downstream enq.
// master = the burst-sum consumer, slave = the surrounding FIFOs.
interface fifo_burst_sum_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] in_first;
  logic              in_first__RDY;
  logic              in_deq__RDY;
  logic              in_deq__ENA;
  logic [DATA_W-1:0] out_enq_v;
  logic              out_enq__ENA;
  logic              out_enq__RDY;

  modport master (
    input  in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
    output in_deq__ENA, out_enq_v, out_enq__ENA
  );
  modport slave (
    output in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
    input  in_deq__ENA, out_enq_v, out_enq__ENA
  );
endinterface

// File: rtl/fifo_burst_sum_acc.sv
// Burst accumulator adder. FIFO_BURST_SUM_SAT_EN selects a saturating
// DATA_W+1-bit add with overflow flag; otherwise the sum wraps.
module fifo_burst_sum_acc #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] word,
  input  logic              first,
  output logic [DATA_W-1:0] next_acc,
  output logic              ovf
);
`ifdef FIFO_BURST_SUM_SAT_EN
  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, word};
    next_acc = sum[DATA_W-1:0];
    ovf      = 1'b0;
    // Once saturated, any further add either carries again or adds zero.
    if (sum[DATA_W]) begin
      next_acc = '1;
      ovf      = 1'b1;
    end
    if (first) begin
      next_acc = word;
      ovf      = 1'b0;
    end
  end
`else
  always_comb begin
    next_acc = first ? word : acc + word;
    ovf      = 1'b0;
  end
`endif
endmodule

// File: rtl/fifo_burst_sum.sv
// Pulls BURST_LEN words from an upstream FIFO, emits their sum downstream.
// Saturation is selected by FIFO_BURST_SUM_SAT_EN inside fifo_burst_sum_acc.
module fifo_burst_sum
  import fifo_burst_sum_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  fifo_burst_sum_if.master    bus,
  output logic [BURSTS_W-1:0] bursts_done,
  output logic                busy,
  output logic                sum_ovf
);
  localparam int CNT_W = clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] acc, acc_nx, next_acc;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              take, emit_fire, first, ovf;

  // Outputs are gated by nRST so they read 0 while reset is held.
  assign emit_fire = nRST && (state == EMIT) && bus.out_enq__RDY;
  assign take      = nRST && bus.in_first__RDY && bus.in_deq__RDY &&
                     ((state == COLLECT) || emit_fire);
  assign first     = (state == EMIT) || (cnt == '0);

  assign bus.in_deq__ENA  = take;
  assign bus.out_enq__ENA = nRST && (state == EMIT);
  assign bus.out_enq_v    = nRST ? acc : '0;
  assign busy             = nRST && ((state != COLLECT) || (cnt != '0));

  fifo_burst_sum_acc #(.DATA_W(DATA_W)) u_acc (
    .acc      (acc),
    .word     (bus.in_first),
    .first    (first),
    .next_acc (next_acc),
    .ovf      (ovf)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= COLLECT;
      acc         <= '0;
      cnt         <= '0;
      bursts_done <= '0;
      sum_ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      if (emit_fire) bursts_done <= bursts_done + 1'b1;
      if (take && ovf) sum_ovf <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    case (state)
      COLLECT: if (take) begin
        acc_nx = next_acc;
        if (cnt == LAST) begin
          state_nx = EMIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      EMIT: if (emit_fire) begin
        state_nx = COLLECT;
        // Back-to-back: the first word of the next burst is taken this cycle.
        if (take) begin
          acc_nx = next_acc;
          cnt_nx = CNT_W'(1);
        end
      end
      default: state_nx = COLLECT;
    endcase
  end
endmodule

// File: tb/tb_fifo_burst_sum.sv
// Directed bench for fifo_burst_sum with a scoreboard of expected burst sums.
module tb_fifo_burst_sum;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] bursts_done;
  logic        busy, sum_ovf;

  fifo_burst_sum_if #(.DATA_W(32)) bus();

  fifo_burst_sum #(.DATA_W(32), .BURST_LEN(4)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus.master),
    .bursts_done (bursts_done),
    .busy        (busy),
    .sum_ovf     (sum_ovf)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          emits = 0;
  logic [31:0] sb[$];
  logic [31:0] m_acc = '0;
  int          m_cnt = 0;
  int          exp_bursts = 0;

`ifdef FIFO_BURST_SUM_SAT_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Independent reference for the accumulator.
  task automatic model_word(input logic [31:0] w);
    logic [32:0] s;
    if (m_cnt == 0) m_acc = w;
    else begin
      s = {1'b0, m_acc} + {1'b0, w};
`ifdef FIFO_BURST_SUM_SAT_EN
      m_acc = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
      m_acc = s[31:0];
`endif
    end
    m_cnt++;
    if (m_cnt == 4) begin
      sb.push_back(m_acc);
      exp_bursts++;
      m_cnt = 0;
    end
  endtask

  // Offer one word; returns how many cycles it waited before being dequeued.
  task automatic put(input logic [31:0] w, output int waited);
    bit fired;
    fired  = 0;
    waited = 0;
    bus.in_first      = w;
    bus.in_first__RDY = 1'b1;
    while (!fired && waited < 40) begin
      @(negedge CLK);
      if (bus.in_deq__ENA) fired = 1;
      else waited++;
    end
    @(posedge CLK); #1;
    if (!fired) chk("put_timeout", 32'(waited), 32'd0);
    else model_word(w);
  endtask

  task automatic idle(input int n);
    bus.in_first__RDY = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.in_first__RDY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_deq_ena", 32'(bus.in_deq__ENA), 32'd0);
    chk("rst_enq_ena", 32'(bus.out_enq__ENA), 32'd0);
    chk("rst_enq_v",   bus.out_enq_v, 32'd0);
    chk("rst_bursts",  32'(bursts_done), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_ovf",     32'(sum_ovf), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    bus.in_first__RDY = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    exp_bursts = 0;
    sb.delete();
  endtask

  // Output monitor: pops scoreboard on every enqueue, checks deq gating.
  always @(negedge CLK) begin
    if (bus.out_enq__ENA && bus.out_enq__RDY) begin
      emits++;
      if (sb.size() == 0) chk("enq_unexpected", 32'(sb.size()), 32'd1);
      else chk("enq_v", bus.out_enq_v, sb.pop_front());
    end
    if (!bus.in_first__RDY) chk("deq_while_empty", 32'(bus.in_deq__ENA), 32'd0);
  end

  initial begin
    int w, e0;
    bus.in_first      = '0;
    bus.in_first__RDY = 1'b0;
    bus.in_deq__RDY   = 1'b1;
    bus.out_enq__RDY  = 1'b1;

    do_reset();

    // Single burst 1..4 -> 10, result one cycle after the last deq
    for (int i = 1; i <= 4; i++) put(32'(i), w);
    bus.in_first__RDY = 1'b0;
    @(negedge CLK);
    chk("b1_enq_ena", 32'(bus.out_enq__ENA), 32'd1);
    chk("b1_enq_v",   bus.out_enq_v, 32'd10);
    @(negedge CLK);
    chk("b1_enq_ena_off", 32'(bus.out_enq__ENA), 32'd0);
    chk("b1_bursts",      32'(bursts_done), 32'(exp_bursts));
    chk("b1_busy",        32'(busy), 32'd0);
    @(posedge CLK); #1;

    // Downstream stall for 5 cycles with upstream data waiting
    bus.out_enq__RDY = 1'b0;
    for (int i = 5; i <= 8; i++) put(32'(i), w);
    bus.in_first = 32'd9;
    bus.in_first__RDY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_enq_ena", 32'(bus.out_enq__ENA), 32'd1);
      chk("hold_enq_v",   bus.out_enq_v, 32'd26);
      chk("hold_deq",     32'(bus.in_deq__ENA), 32'd0);
    end
    @(posedge CLK); #1;
    e0 = emits;
    bus.in_first__RDY = 1'b0;
    bus.out_enq__RDY  = 1'b1;
    idle(4);
    chk("hold_one_enq", 32'(emits), 32'(e0 + 1));

    // Gapless stream of 8 words: no bubble at burst boundary
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      put(32'(i), w);
      chk("stream_no_stall", 32'(w), 32'd0);
    end
    idle(3);
    chk("stream_bursts", 32'(bursts_done), 32'd2);
    chk("stream_sb_drained", 32'(sb.size()), 32'd0);

    // Same words with upstream RDY toggling every cycle
    for (int i = 1; i <= 8; i++) begin
      put(32'(i), w);
      idle(1);
    end
    idle(3);
    chk("gap_bursts", 32'(bursts_done), 32'd4);
    chk("gap_sb_drained", 32'(sb.size()), 32'd0);

    // Carry out of the adder
    do_reset();
    put(32'hFFFF_FFFF, w);
    put(32'd2, w);
    put(32'd0, w);
    put(32'd0, w);
    idle(3);
    chk("ovf_flag", 32'(sum_ovf), 32'(EXP_OVF));
    chk("ovf_sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-burst discards the partial sum
    do_reset();
    put(32'd7, w);
    put(32'd7, w);
    do_reset();
    for (int i = 0; i < 4; i++) put(32'd5, w);
    idle(3);
    chk("midrst_bursts", 32'(bursts_done), 32'd1);
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_ovf",    32'(sum_ovf), 32'd0);
    chk("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
